hex_count_source: RTL
=====================

Name: hex_count_source

Overview:
- Upstream source for the 7-segment stage: a 16-bit up/down hex counter whose four nibbles feed four hex-to-segment decoders, HEX0..HEX3.
- Driven from board keys and switches: debounced run/stop toggle, single-step, direction select, parallel load.
- Free-runs at a prescaled tick rate or advances one count per step press.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per count tick while running; 1 Hz at 50 MHz; must be >= 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a key level is accepted; 20 ms at 50 MHz; must be >= 1.

Ports:
- CLOCK_50  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run_key  in  1  raw asynchronous key, active-high; each accepted press toggles run/stop.
- step_key  in  1  raw asynchronous key, active-high; each accepted press advances the count by one while stopped.
- up_down  in  1  direction, 1 = increment, 0 = decrement; sampled on each count event.
- load  in  1  level; while high, count is forced to load_value.
- load_value  in  16  parallel load value, typically switches SW[15:0].
- digits  out  16  count value; nibble [4k+3:4k] drives HEX digit k.
- running  out  1  1 while in RUNNING.
- wrap  out  1  one-cycle pulse on wrap-around.

Behaviour:
- Reset (synchronous, highest priority):
  - digits = 16'h0000, running = 0, wrap = 0.
  - State = STOPPED, prescaler = 0.
  - Debouncer synchronisers, counters and accepted levels = 0.
  - Any partially debounced press is discarded.
- Key path, per key:
  - 2-flop synchroniser.
  - Debounce counter: a synchronised level differing from the accepted level for DEBOUNCE_CYCLES consecutive cycles becomes the new accepted level; any reversion restarts the counter.
  - press = one-cycle pulse on an accepted 0->1 transition.
  - Release generates nothing.
- FSM, states STOPPED and RUNNING:
  - STOPPED --run press--> RUNNING. RUNNING --run press--> STOPPED.
  - running = (state == RUNNING), registered.
  - Prescaler is cleared on entry to RUNNING.
- Prescaler:
  - In RUNNING, counts 0..TICK_DIV-1.
  - tick = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - Held at 0 in STOPPED and while load = 1.
- Count event:
  - In RUNNING: tick.
  - In STOPPED: step press.
  - Step presses in RUNNING are ignored.
- Update priority: reset > load > count event.
  - load = 1: count <= load_value every cycle, no wrap pulse, FSM state unchanged; run presses still toggle state.
  - Count event with up_down = 1: count <= count + 1, mod 2^16.
  - Count event with up_down = 0: count <= count - 1, mod 2^16.
- Latency:
  - digits shows the new value in the cycle after the event, or after load is sampled.
  - wrap is asserted in that same cycle, for exactly one cycle.
- Wrap boundaries:
  - Up: FFFF -> 0000 asserts wrap.
  - Down: 0000 -> FFFF asserts wrap.
  - No other transition asserts wrap.
- Simultaneous events:
  - run press and tick in the same cycle: count advances and state becomes STOPPED.
  - run press and load: count loads and state toggles.
- Digit nibbles carry no inter-digit BCD logic; the count is pure binary/hex.

Decomposition:
- Shared package hex_count_pkg:
  - State encoding ST_STOPPED = 1'b0, ST_RUNNING = 1'b1.
  - NUM_DIGITS = 4, DIGIT_W = 4, COUNT_W = 16.
- One sub-module, key_debounce (synchroniser + debounce counter + rising-edge press pulse, parameter DEBOUNCE_CYCLES), instanced for run_key and step_key.
- Prescaler, FSM and counter stay in the top.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
- Reset, then assert reset for 1 cycle mid-run at count 0x0005 -> next cycle digits = 0000, running = 0, wrap = 0; no count for the following 10 idle cycles.
- STOPPED, up_down=1, step_key high for 10 cycles -> digits 0000 -> 0001 exactly once. A 2-cycle step_key glitch -> no change.
- Run press, up_down=1 -> running = 1; digits increments every 4 cycles (0001, 0002, 0003). Step presses during RUNNING -> no extra counts.
- load=1 with load_value=16'hFFFE for 1 cycle, then run -> FFFF, then 0000 with wrap = 1 for one cycle. Then up_down=0 -> next tick FFFF with wrap = 1.
- load=1 in the tick cycle with load_value=16'h1234 -> digits = 1234, wrap = 0, prescaler restarts; next increment to 1235 occurs 4 cycles after load drops.
- Run press accepted in the same cycle as a tick at 0x0010 -> digits = 0011, running = 0; no further ticks. Reset asserted while run_key is mid-debounce -> no toggle occurs.

Source files
------------

// File: rtl/hex_count_pkg.sv
// hex_count_pkg
//   Shared constants and helpers for the hex counter source feeding the
//   seven-segment stage: digit geometry, run/stop state encoding and the
//   single-step count arithmetic with wrap detection.
package hex_count_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned COUNT_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  typedef logic [COUNT_W-1:0] count_t;

  typedef struct packed {
    logic   wrap;
    count_t value;
  } step_result_t;

  // One count step in the requested direction; wrap flags the modular rollover.
  function automatic step_result_t count_step(input count_t cur, input logic up);
    step_result_t r;
    if (up) begin
      r.value = cur + count_t'(1);
      r.wrap  = (cur == '1);
    end else begin
      r.value = cur - count_t'(1);
      r.wrap  = (cur == '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_count_source_key_debounce.sv
// key_debounce
//   Conditions one raw asynchronous push-button: two-flop synchroniser,
//   stability counter, and a one-cycle press pulse on an accepted 0->1
//   level change. Releases are debounced the same way but emit nothing.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-high reset; discards any partial press
//   key_raw  in  raw key level, active-high, asynchronous
//   press    out one-cycle pulse per accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // cnt_q counts differing cycles already seen; the cycle where it reaches
    // CNT_LAST is the DEBOUNCE_CYCLES-th consecutive one, so accept there.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hex_count_source.sv
// hex_count_source
//   16-bit up/down hex counter driving four seven-segment digit decoders.
//   A debounced run key toggles free-running (one count per TICK_DIV clocks)
//   versus stopped; a debounced step key advances one count while stopped;
//   load forces the count to load_value every cycle it is high.
// Ports:
//   CLOCK_50    in  system clock, rising edge
//   reset       in  synchronous active-high reset
//   run_key     in  raw run/stop toggle key, active-high
//   step_key    in  raw single-step key, active-high
//   up_down     in  1 = increment, 0 = decrement
//   load        in  level, forces count to load_value
//   load_value  in  parallel load value
//   digits      out count; nibble [4k+3:4k] drives HEX digit k
//   running     out 1 while running
//   wrap        out one-cycle pulse on FFFF->0000 or 0000->FFFF
module hex_count_source
  import hex_count_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               run_key,
  input  logic               step_key,
  input  logic               up_down,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  output logic [COUNT_W-1:0] digits,
  output logic               running,
  output logic               wrap
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             run_press;
  logic             step_press;
  logic             tick;
  logic             count_evt;
  step_result_t     step;

  logic [0:0]       state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  count_t           count_q, count_d;
  logic             wrap_q, wrap_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk     (CLOCK_50),
    .reset   (reset),
    .key_raw (run_key),
    .press   (run_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (CLOCK_50),
    .reset   (reset),
    .key_raw (step_key),
    .press   (step_press)
  );

  always_comb begin
    tick      = (state_q == ST_RUNNING) && (presc_q == PRE_LAST);
    state_d   = run_press ? ~state_q : state_q;

    // Any run press also zeroes the prescaler: leaving RUNNING parks it at 0,
    // and entering RUNNING already starts from 0 because STOPPED holds it there.
    if ((state_q != ST_RUNNING) || load || run_press || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    count_evt = (state_q == ST_RUNNING) ? tick : step_press;
    step      = count_step(count_q, up_down);

    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (count_evt) begin
      count_d = step.value;
      wrap_d  = step.wrap;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digits  = count_q;
  assign running = (state_q == ST_RUNNING);
  assign wrap    = wrap_q;

endmodule
